// File: rtl/vec_decode_cfg.sv
// Registered vector instruction decoder with vl/vtype configuration state.
// One instruction per cycle in, one-entry decode packet out, vset* executed in place.
module vec_decode_cfg #(
    parameter int XLEN = 32,
    parameter int VLEN = 512,
    parameter int ELEN = 32,
    parameter int VL_W = $clog2(VLEN) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            inst_valid,
    output logic            inst_ready,
    input  logic [31:0]     vec_inst,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            is_vec,
    output logic            illegal,
    output logic            is_cfg,
    output logic            is_load,
    output logic [4:0]      vd_addr,
    output logic [4:0]      vs1_addr,
    output logic [4:0]      vs2_addr,
    output logic [XLEN-1:0] vec_imm,
    output logic            vec_mask,
    output logic [2:0]      width,
    output logic [1:0]      mop,
    output logic [2:0]      nf,
    output logic            mew,
    output logic [XLEN-1:0] scalar1,
    output logic [XLEN-1:0] scalar2,
    output logic [XLEN-1:0] rd_wdata,
    output logic [VL_W-1:0] vl,
    output logic [XLEN-1:0] vtype
);

    localparam logic [6:0]      OPC_V      = 7'h57;
    localparam logic [6:0]      OPC_LD     = 7'h07;
    localparam logic [XLEN-1:0] VTYPE_VILL = {1'b1, {(XLEN-1){1'b0}}};

    typedef struct packed {
        logic            is_vec;
        logic            illegal;
        logic            is_cfg;
        logic            is_load;
        logic [4:0]      vd_addr;
        logic [4:0]      vs1_addr;
        logic [4:0]      vs2_addr;
        logic [XLEN-1:0] vec_imm;
        logic            vec_mask;
        logic [2:0]      width;
        logic [1:0]      mop;
        logic [2:0]      nf;
        logic            mew;
        logic [XLEN-1:0] scalar1;
        logic [XLEN-1:0] scalar2;
        logic [XLEN-1:0] rd_wdata;
    } pkt_t;

    pkt_t            pkt_q, pkt_d, dec;
    logic            out_valid_q, out_valid_d;
    logic [VL_W-1:0] vl_q, vl_d;
    logic [XLEN-1:0] vtype_q, vtype_d;
    logic            accept;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rd, rs1, rs2f;

    assign opcode = vec_inst[6:0];
    assign funct3 = vec_inst[14:12];
    assign rd     = vec_inst[11:7];
    assign rs1    = vec_inst[19:15];
    assign rs2f   = vec_inst[24:20];

    // Elements per register at LMUL=1 for each supported vsew encoding
    logic [VL_W-1:0] elems_per_reg [4];
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sew
            assign elems_per_reg[gi] = VL_W'(VLEN >> (gi + 3));
        end
    endgenerate

    logic            cfg_vli, cfg_ivli, cfg_vl, cfg_ok;
    logic [XLEN-1:0] cfg_vtype, avl, vlmax_x, old_vl_x, new_vl_x;
    logic [2:0]      vlmul, vsew;
    logic [31:0]     sew_bits;
    logic            vtype_legal;
    logic [VL_W-1:0] vlmax;

    always_comb begin
        cfg_vli  = !vec_inst[31];
        cfg_ivli = (vec_inst[31:30] == 2'b11);
        cfg_vl   = (vec_inst[31:25] == 7'b1000000);
        cfg_ok   = cfg_vli || cfg_ivli || cfg_vl;

        if (cfg_vli) begin
            cfg_vtype = XLEN'(vec_inst[30:20]);
        end else if (cfg_ivli) begin
            cfg_vtype = XLEN'(vec_inst[29:20]);
        end else begin
            cfg_vtype = rs2_data;
        end

        vlmul    = cfg_vtype[2:0];
        vsew     = cfg_vtype[5:3];
        sew_bits = 32'd8 << vsew;

        // A requested vill bit is treated like any other reserved bit
        vtype_legal = (vlmul != 3'b100) && (sew_bits <= 32'(ELEN)) && !(|cfg_vtype[XLEN-1:8]);
        if (vlmul[2] && ((sew_bits << (4'd8 - {1'b0, vlmul})) > 32'(ELEN))) begin
            vtype_legal = 1'b0;
        end

        if (vlmul[2]) begin
            vlmax = elems_per_reg[vsew[1:0]] >> (4'd8 - {1'b0, vlmul});
        end else begin
            vlmax = elems_per_reg[vsew[1:0]] << vlmul[1:0];
        end

        vlmax_x  = {{(XLEN-VL_W){1'b0}}, vlmax};
        old_vl_x = {{(XLEN-VL_W){1'b0}}, vl_q};
        avl      = cfg_ivli ? XLEN'(vec_inst[19:15]) : rs1_data;

        if (!cfg_ivli && (rs1 == 5'd0)) begin
            if (rd != 5'd0) begin
                new_vl_x = vlmax_x;
            end else begin
                new_vl_x = (old_vl_x < vlmax_x) ? old_vl_x : vlmax_x;
            end
        end else begin
            new_vl_x = (avl < vlmax_x) ? avl : vlmax_x;
        end
    end

    always_comb begin
        dec = '0;
        if (opcode == OPC_V) begin
            dec.is_vec = 1'b1;
            case (funct3)
                3'b000, 3'b011, 3'b100: begin
                    dec.illegal  = vtype_q[XLEN-1];
                    dec.vd_addr  = rd;
                    dec.vs2_addr = rs2f;
                    dec.vec_mask = vec_inst[25];
                    if (funct3 == 3'b000) begin
                        dec.vs1_addr = rs1;
                    end
                    if (funct3 == 3'b011) begin
                        dec.vec_imm = {{(XLEN-5){vec_inst[19]}}, vec_inst[19:15]};
                    end
                end
                3'b111: begin
                    dec.is_cfg  = 1'b1;
                    dec.vd_addr = rd;
                    if (!cfg_ok) begin
                        dec.illegal = 1'b1;
                    end else if (vtype_legal) begin
                        dec.rd_wdata = new_vl_x;
                    end
                end
                default: dec.illegal = 1'b1;
            endcase
        end else if (opcode == OPC_LD) begin
            dec.is_vec   = 1'b1;
            dec.is_load  = 1'b1;
            dec.vd_addr  = rd;
            dec.vec_mask = vec_inst[25];
            dec.width    = funct3;
            dec.mop      = vec_inst[27:26];
            dec.mew      = vec_inst[28];
            dec.nf       = vec_inst[31:29];
            dec.scalar1  = rs1_data;
            case (vec_inst[27:26])
                2'b00:   dec.scalar2  = XLEN'(rs2f);
                2'b10:   dec.scalar2  = rs2_data;
                default: dec.vs2_addr = rs2f;
            endcase
        end
    end

    assign inst_ready = !out_valid_q || out_ready;

    // CSRs change on the accepting edge so the very next instruction sees them
    always_comb begin
        accept      = inst_valid && inst_ready;
        out_valid_d = out_valid_q;
        pkt_d       = pkt_q;
        vl_d        = vl_q;
        vtype_d     = vtype_q;
        if (accept) begin
            out_valid_d = 1'b1;
            pkt_d       = dec;
            if ((opcode == OPC_V) && (funct3 == 3'b111) && cfg_ok) begin
                if (vtype_legal) begin
                    vtype_d = cfg_vtype;
                    vl_d    = new_vl_x[VL_W-1:0];
                end else begin
                    vtype_d = VTYPE_VILL;
                    vl_d    = '0;
                end
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            pkt_q       <= '0;
            vl_q        <= '0;
            vtype_q     <= VTYPE_VILL;
        end else begin
            out_valid_q <= out_valid_d;
            pkt_q       <= pkt_d;
            vl_q        <= vl_d;
            vtype_q     <= vtype_d;
        end
    end

    assign out_valid = out_valid_q;
    assign is_vec    = pkt_q.is_vec;
    assign illegal   = pkt_q.illegal;
    assign is_cfg    = pkt_q.is_cfg;
    assign is_load   = pkt_q.is_load;
    assign vd_addr   = pkt_q.vd_addr;
    assign vs1_addr  = pkt_q.vs1_addr;
    assign vs2_addr  = pkt_q.vs2_addr;
    assign vec_imm   = pkt_q.vec_imm;
    assign vec_mask  = pkt_q.vec_mask;
    assign width     = pkt_q.width;
    assign mop       = pkt_q.mop;
    assign nf        = pkt_q.nf;
    assign mew       = pkt_q.mew;
    assign scalar1   = pkt_q.scalar1;
    assign scalar2   = pkt_q.scalar2;
    assign rd_wdata  = pkt_q.rd_wdata;
    assign vl        = vl_q;
    assign vtype     = vtype_q;

endmodule

// File: tb/tb_vec_decode_cfg.sv
// Table-driven bench for vec_decode_cfg with an in-order scoreboard on the packet port.
module tb_vec_decode_cfg;
    localparam int XLEN = 32;
    localparam int VLEN = 512;
    localparam int ELEN = 32;
    localparam int VL_W = 10;

    logic            clk, reset, inst_valid, inst_ready, out_valid, out_ready;
    logic [31:0]     vec_inst;
    logic [XLEN-1:0] rs1_data, rs2_data, vec_imm, scalar1, scalar2, rd_wdata, vtype;
    logic            is_vec, illegal, is_cfg, is_load, vec_mask, mew;
    logic [4:0]      vd_addr, vs1_addr, vs2_addr;
    logic [2:0]      width, nf;
    logic [1:0]      mop;
    logic [VL_W-1:0] vl;

    vec_decode_cfg #(.XLEN(XLEN), .VLEN(VLEN), .ELEN(ELEN), .VL_W(VL_W)) dut (
        .clk(clk), .reset(reset), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .vec_inst(vec_inst), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .out_valid(out_valid), .out_ready(out_ready), .is_vec(is_vec), .illegal(illegal),
        .is_cfg(is_cfg), .is_load(is_load), .vd_addr(vd_addr), .vs1_addr(vs1_addr),
        .vs2_addr(vs2_addr), .vec_imm(vec_imm), .vec_mask(vec_mask), .width(width),
        .mop(mop), .nf(nf), .mew(mew), .scalar1(scalar1), .scalar2(scalar2),
        .rd_wdata(rd_wdata), .vl(vl), .vtype(vtype)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] inst, rs1d, rs2d;
        logic [3:0]  flags;   // {is_vec, illegal, is_cfg, is_load}
        logic [4:0]  vd, vs1, vs2;
        logic [31:0] imm;
        logic        vm;
        logic [2:0]  width;
        logic [1:0]  mop;
        logic [2:0]  nf;
        logic        mew;
        logic [31:0] s1, s2, rdw;
        logic        chk_csr;
        logic [9:0]  exp_vl;
        logic [31:0] exp_vtype;
    } vec_t;

    vec_t tbl[$];
    vec_t strm[$];
    vec_t exp_q[$];
    vec_t v, mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [31:0] e_vsetvli(logic [4:0] rd, logic [4:0] r1, logic [10:0] vt);
        return {1'b0, vt, r1, 3'b111, rd, 7'h57};
    endfunction
    function automatic logic [31:0] e_vsetivli(logic [4:0] rd, logic [4:0] uimm, logic [9:0] vt);
        return {2'b11, vt, uimm, 3'b111, rd, 7'h57};
    endfunction
    function automatic logic [31:0] e_vsetvl(logic [6:0] top, logic [4:0] rd, logic [4:0] r1, logic [4:0] r2);
        return {top, r2, r1, 3'b111, rd, 7'h57};
    endfunction
    function automatic logic [31:0] e_arith(logic vm, logic [4:0] vs2, logic [4:0] r1, logic [2:0] f3, logic [4:0] vd);
        return {6'd0, vm, vs2, r1, f3, vd, 7'h57};
    endfunction
    function automatic logic [31:0] e_load(logic [2:0] nfv, logic mw, logic [1:0] mp, logic vm,
                                          logic [4:0] r2, logic [4:0] r1, logic [2:0] w, logic [4:0] vd);
        return {nfv, mw, mp, vm, r2, r1, w, vd, 7'h07};
    endfunction

    function automatic vec_t mk(string name, logic [31:0] inst, logic [31:0] r1d, logic [31:0] r2d);
        vec_t r;
        r.name = name; r.inst = inst; r.rs1d = r1d; r.rs2d = r2d;
        r.flags = 4'b0; r.vd = 0; r.vs1 = 0; r.vs2 = 0; r.imm = 0; r.vm = 0;
        r.width = 0; r.mop = 0; r.nf = 0; r.mew = 0; r.s1 = 0; r.s2 = 0; r.rdw = 0;
        r.chk_csr = 0; r.exp_vl = 0; r.exp_vtype = 0;
        return r;
    endfunction

    function automatic vec_t csr(vec_t r, logic [9:0] evl, logic [31:0] evt);
        r.chk_csr = 1'b1; r.exp_vl = evl; r.exp_vtype = evt;
        return r;
    endfunction

    function automatic bit pkt_match(vec_t e);
        return ({is_vec, illegal, is_cfg, is_load} === e.flags) && (vd_addr === e.vd) &&
               (vs1_addr === e.vs1) && (vs2_addr === e.vs2) && (vec_imm === e.imm) &&
               (vec_mask === e.vm) && (width === e.width) && (mop === e.mop) && (nf === e.nf) &&
               (mew === e.mew) && (scalar1 === e.s1) && (scalar2 === e.s2) && (rd_wdata === e.rdw);
    endfunction

    task automatic report_pkt(string tag, vec_t e);
        $display("FAIL %s %s: got flags=%b vd=%0d vs1=%0d vs2=%0d imm=%h vm=%b w=%0d mop=%0d nf=%0d mew=%b s1=%h s2=%h rdw=%h | required flags=%b vd=%0d vs1=%0d vs2=%0d imm=%h vm=%b w=%0d mop=%0d nf=%0d mew=%b s1=%h s2=%h rdw=%h",
                 tag, e.name, {is_vec, illegal, is_cfg, is_load}, vd_addr, vs1_addr, vs2_addr, vec_imm,
                 vec_mask, width, mop, nf, mew, scalar1, scalar2, rd_wdata,
                 e.flags, e.vd, e.vs1, e.vs2, e.imm, e.vm, e.width, e.mop, e.nf, e.mew, e.s1, e.s2, e.rdw);
    endtask

    // Scoreboard: pop on transfer, check hold-stability during stalls
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (exp_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_pkt: got out_valid=1 with nothing outstanding, required 0");
            end else if (out_ready) begin
                mon_e = exp_q.pop_front();
                n_tests++;
                if (!pkt_match(mon_e)) begin
                    n_fail++; report_pkt("pkt", mon_e);
                end
                if (mon_e.chk_csr) begin
                    n_tests++;
                    if (vl !== mon_e.exp_vl || vtype !== mon_e.exp_vtype) begin
                        n_fail++;
                        $display("FAIL csr %s: got vl=%0d vtype=%h, required vl=%0d vtype=%h",
                                 mon_e.name, vl, vtype, mon_e.exp_vl, mon_e.exp_vtype);
                    end
                end
            end else begin
                n_tests++;
                if (!pkt_match(exp_q[0]) || inst_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall_hold inst_ready: got %b, required 0", inst_ready);
                    report_pkt("stall_pkt", exp_q[0]);
                end
            end
        end
    end

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, got, exp);
        end
    endtask

    task automatic send(input vec_t sv);
        int guard;
        bit ok;
        guard = 0; ok = 1'b0;
        inst_valid = 1'b1; vec_inst = sv.inst; rs1_data = sv.rs1d; rs2_data = sv.rs2d;
        while (!ok && guard < 50) begin
            @(negedge clk);
            ok = inst_ready;
            if (ok) exp_q.push_back(sv);
            @(posedge clk);
            #1;
            guard++;
        end
        if (!ok) begin
            n_tests++; n_fail++;
            $display("FAIL accept_timeout %s: got inst_ready=0, required 1", sv.name);
        end
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 50) begin
            @(posedge clk);
            g++;
        end
        #1;
        if (exp_q.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL drain_timeout: got %0d packets outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; inst_valid = 1'b0; vec_inst = 0; rs1_data = 0; rs2_data = 0; out_ready = 1'b1;

        v = mk("vv_vill", e_arith(1, 2, 3, 3'b000, 1), 0, 0);
        v.flags = 4'b1100; v.vd = 1; v.vs1 = 3; v.vs2 = 2; v.vm = 1; tbl.push_back(csr(v, 0, 32'h8000_0000));
        v = mk("vsetvli_e32m2", e_vsetvli(5, 6, 11'h011), 100, 0);
        v.flags = 4'b1010; v.vd = 5; v.rdw = 32; tbl.push_back(csr(v, 32, 32'h11));
        v = mk("vsetivli_e8mf2", e_vsetivli(7, 5, 10'h007), 0, 0);
        v.flags = 4'b1010; v.vd = 7; v.rdw = 5; tbl.push_back(csr(v, 5, 32'h07));
        v = mk("vsetvli_keep", e_vsetvli(0, 0, 11'h008), 32'h1234, 0);
        v.flags = 4'b1010; v.rdw = 5; tbl.push_back(csr(v, 5, 32'h08));
        v = mk("vsetvli_vlmax", e_vsetvli(3, 0, 11'h010), 0, 0);
        v.flags = 4'b1010; v.vd = 3; v.rdw = 16; tbl.push_back(csr(v, 16, 32'h10));
        v = mk("vadd_vi", e_arith(0, 4, 5'b11110, 3'b011, 2), 0, 0);
        v.flags = 4'b1000; v.vd = 2; v.vs2 = 4; v.imm = 32'hFFFF_FFFE; tbl.push_back(csr(v, 16, 32'h10));
        v = mk("vadd_vx", e_arith(1, 9, 10, 3'b100, 8), 32'h55, 0);
        v.flags = 4'b1000; v.vd = 8; v.vs2 = 9; v.vm = 1; tbl.push_back(csr(v, 16, 32'h10));
        v = mk("vadd_vv", e_arith(1, 2, 3, 3'b000, 1), 0, 0);
        v.flags = 4'b1000; v.vd = 1; v.vs1 = 3; v.vs2 = 2; v.vm = 1; tbl.push_back(csr(v, 16, 32'h10));
        v = mk("ld_strided", e_load(0, 0, 2'b10, 1, 11, 12, 3'b110, 4), 32'h1000, 16);
        v.flags = 4'b1001; v.vd = 4; v.vm = 1; v.width = 6; v.mop = 2; v.s1 = 32'h1000; v.s2 = 16;
        tbl.push_back(csr(v, 16, 32'h10));
        v = mk("ld_unit", e_load(3'b001, 0, 2'b00, 0, 8, 12, 3'b000, 6), 32'h2000, 32'hDEAD);
        v.flags = 4'b1001; v.vd = 6; v.nf = 1; v.s1 = 32'h2000; v.s2 = 8; tbl.push_back(csr(v, 16, 32'h10));
        v = mk("ld_indexed", e_load(0, 1, 2'b01, 1, 13, 12, 3'b101, 7), 32'h3000, 32'h77);
        v.flags = 4'b1001; v.vd = 7; v.vm = 1; v.width = 5; v.mop = 1; v.mew = 1; v.vs2 = 13; v.s1 = 32'h3000;
        tbl.push_back(csr(v, 16, 32'h10));
        v = mk("opmvv_unsup", e_arith(1, 2, 3, 3'b010, 1), 0, 0);
        v.flags = 4'b1100; tbl.push_back(csr(v, 16, 32'h10));
        v = mk("scalar_add", 32'h0020_8033, 5, 6);
        tbl.push_back(csr(v, 16, 32'h10));
        v = mk("vsetvli_e64_ill", e_vsetvli(5, 6, 11'h018), 10, 0);
        v.flags = 4'b1010; v.vd = 5; tbl.push_back(csr(v, 0, 32'h8000_0000));
        v = mk("vsetvli_e32m1", e_vsetvli(5, 6, 11'h010), 20, 0);
        v.flags = 4'b1010; v.vd = 5; v.rdw = 16; tbl.push_back(csr(v, 16, 32'h10));
        v = mk("vsetvl_lmul100", e_vsetvl(7'b1000000, 5, 6, 7), 8, 32'h4);
        v.flags = 4'b1010; v.vd = 5; tbl.push_back(csr(v, 0, 32'h8000_0000));
        v = mk("vv_after_vill", e_arith(1, 2, 3, 3'b000, 1), 0, 0);
        v.flags = 4'b1100; v.vd = 1; v.vs1 = 3; v.vs2 = 2; v.vm = 1; tbl.push_back(csr(v, 0, 32'h8000_0000));
        v = mk("vsetvl_e32m8", e_vsetvl(7'b1000000, 5, 6, 7), 1000, 32'h13);
        v.flags = 4'b1010; v.vd = 5; v.rdw = 128; tbl.push_back(csr(v, 128, 32'h13));
        v = mk("vsetvl_rsvd", e_vsetvl(7'b1000000, 5, 6, 7), 8, 32'h100);
        v.flags = 4'b1010; v.vd = 5; tbl.push_back(csr(v, 0, 32'h8000_0000));
        v = mk("vsetvli_e32mf2", e_vsetvli(5, 6, 11'h017), 10, 0);
        v.flags = 4'b1010; v.vd = 5; tbl.push_back(csr(v, 0, 32'h8000_0000));
        v = mk("vsetvli_e16mf2", e_vsetvli(5, 6, 11'h00F), 32'hFFFF_FFFF, 0);
        v.flags = 4'b1010; v.vd = 5; v.rdw = 16; tbl.push_back(csr(v, 16, 32'h0F));
        v = mk("cfg_bad_form", e_vsetvl(7'b1000001, 4, 6, 7), 8, 32'h10);
        v.flags = 4'b1110; v.vd = 4; tbl.push_back(csr(v, 16, 32'h0F));

        v = mk("s_vsetvl_ill", e_vsetvl(7'b1000000, 5, 6, 7), 8, 32'h4);
        v.flags = 4'b1010; v.vd = 5; strm.push_back(v);
        v = mk("s_vv_ill", e_arith(1, 2, 3, 3'b000, 1), 0, 0);
        v.flags = 4'b1100; v.vd = 1; v.vs1 = 3; v.vs2 = 2; v.vm = 1; strm.push_back(v);
        v = mk("s_vsetivli", e_vsetivli(2, 3, 10'h000), 0, 0);
        v.flags = 4'b1010; v.vd = 2; v.rdw = 3; strm.push_back(v);
        v = mk("s_vadd_vi", e_arith(1, 4, 5'b00101, 3'b011, 2), 0, 0);
        v.flags = 4'b1000; v.vd = 2; v.vs2 = 4; v.imm = 5; v.vm = 1; strm.push_back(v);

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_vl", 32'(vl), 0);
        chk("rst_vtype", vtype, 32'h8000_0000);
        chk("rst_inst_ready", 32'(inst_ready), 1);
        chk("rst_pkt_flags", 32'({is_vec, illegal, is_cfg, is_load}), 0);

        for (int i = 0; i < tbl.size(); i++) begin
            send(tbl[i]);
            inst_valid = 1'b0;
            wait_drain();
        end

        fork
            begin
                for (int i = 0; i < strm.size(); i++) send(strm[i]);
                inst_valid = 1'b0;
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_drain();
        chk("stream_vl", 32'(vl), 3);
        chk("stream_vtype", vtype, 32'h0);

        out_ready = 1'b0;
        v = mk("r_vsetivli", e_vsetivli(1, 7, 10'h000), 0, 0);
        v.flags = 4'b1010; v.vd = 1; v.rdw = 7;
        send(v);
        inst_valid = 1'b0;
        chk("pre_rst_vl", 32'(vl), 7);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_vl", 32'(vl), 0);
        chk("midrst_vtype", vtype, 32'h8000_0000);
        chk("midrst_rd_wdata", rd_wdata, 0);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
